// File: rtl/prio_enc_serializer.sv
// Registered priority encoder: streams set-bit indices of a request vector.
// Optional out_last port enabled by defining PRIO_ENC_LAST_EN.
module prio_enc_serializer #(
  parameter int WIDTH     = 4,
  parameter int IDXW      = 2,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] req,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [IDXW-1:0]  out_idx,
`ifdef PRIO_ENC_LAST_EN
  output logic             out_last,
`endif
  output logic             out_none
);

  if (WIDTH < 2 || WIDTH > 32 || (2**IDXW) < WIDTH) begin : g_bad_cfg
    $error("prio_enc_serializer: illegal WIDTH/IDXW");
  end

  typedef enum logic {
    S_IDLE,
    S_DRAIN
  } state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_mask;
  logic [IDXW-1:0]  r_idx;
  logic             r_none;
  logic [WIDTH-1:0] w_clr;
  logic             w_empty;
  logic             w_acc;
  logic             w_beat;

  // Index of the highest or lowest set bit, depending on priority order.
  function automatic logic [IDXW-1:0] pick(input logic [WIDTH-1:0] m);
    logic [IDXW-1:0] r;
    r = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (MSB_FIRST) begin
        if (m[i]) r = IDXW'(i);
      end else begin
        if (m[WIDTH-1-i]) r = IDXW'(WIDTH-1-i);
      end
    end
    return r;
  endfunction

  // True when at most one bit of m is set.
  function automatic logic single(input logic [WIDTH-1:0] m);
    return (m & (m - WIDTH'(1))) == '0;
  endfunction

  // Mask after retiring the bit currently being reported.
  always_comb begin
    w_clr   = r_mask & ~(WIDTH'(1) << r_idx);
    w_empty = r_none || (w_clr == '0);
    w_acc   = (r_state == S_IDLE) && in_valid;
    w_beat  = (r_state == S_DRAIN) && out_ready;
  end

  assign in_ready  = (r_state == S_IDLE);
  assign out_valid = (r_state == S_DRAIN);
  assign out_idx   = r_idx;
  assign out_none  = r_none;

  // Accept a vector in IDLE, retire one bit per handshake in DRAIN.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_mask  <= '0;
      r_idx   <= '0;
      r_none  <= 1'b0;
    end else begin
      unique case (1'b1)
        w_acc: begin
          r_state <= S_DRAIN;
          r_mask  <= req;
          r_idx   <= pick(req);
          r_none  <= (req == '0);
        end
        w_beat: begin
          if (w_empty) begin
            r_state <= S_IDLE;
            r_mask  <= '0;
            r_idx   <= '0;
            r_none  <= 1'b0;
          end else begin
            r_mask <= w_clr;
            r_idx  <= pick(w_clr);
          end
        end
        default: ;
      endcase
    end
  end

`ifdef PRIO_ENC_LAST_EN
  logic r_last;
  assign out_last = r_last;

  // Flag the final beat of each vector, including the all-zero beat.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_last <= 1'b0;
    end else if (w_acc) begin
      r_last <= single(req);
    end else if (w_beat) begin
      r_last <= w_empty ? 1'b0 : single(w_clr);
    end
  end
`endif

endmodule

// File: tb/tb_prio_enc_serializer.sv
// Scoreboard bench for prio_enc_serializer.
// Three instances: W4 MSB-first, W4 LSB-first, W8 MSB-first.
module tb_prio_enc_serializer;

`ifdef PRIO_ENC_LAST_EN
  localparam bit LAST = 1'b1;
`else
  localparam bit LAST = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic       a_iv, a_ir, a_ov, a_ordy, a_none, a_last;
  logic [3:0] a_req;
  logic [1:0] a_idx;
  logic       b_iv, b_ir, b_ov, b_ordy, b_none, b_last;
  logic [3:0] b_req;
  logic [1:0] b_idx;
  logic       c_iv, c_ir, c_ov, c_ordy, c_none, c_last;
  logic [7:0] c_req;
  logic [2:0] c_idx;

  int qa[$];
  int qb[$];
  int qc[$];
  int n_pass = 0;
  int n_tot  = 0;
  bit done;

  prio_enc_serializer #(.WIDTH(4), .IDXW(2), .MSB_FIRST(1'b1)) u_a (
    .clk(clk), .rst_n(rst_n), .in_valid(a_iv), .in_ready(a_ir),
    .req(a_req), .out_valid(a_ov), .out_ready(a_ordy),
    .out_idx(a_idx),
`ifdef PRIO_ENC_LAST_EN
    .out_last(a_last),
`endif
    .out_none(a_none));

  prio_enc_serializer #(.WIDTH(4), .IDXW(2), .MSB_FIRST(1'b0)) u_b (
    .clk(clk), .rst_n(rst_n), .in_valid(b_iv), .in_ready(b_ir),
    .req(b_req), .out_valid(b_ov), .out_ready(b_ordy),
    .out_idx(b_idx),
`ifdef PRIO_ENC_LAST_EN
    .out_last(b_last),
`endif
    .out_none(b_none));

  prio_enc_serializer #(.WIDTH(8), .IDXW(3), .MSB_FIRST(1'b1)) u_c (
    .clk(clk), .rst_n(rst_n), .in_valid(c_iv), .in_ready(c_ir),
    .req(c_req), .out_valid(c_ov), .out_ready(c_ordy),
    .out_idx(c_idx),
`ifdef PRIO_ENC_LAST_EN
    .out_last(c_last),
`endif
    .out_none(c_none));

`ifndef PRIO_ENC_LAST_EN
  assign a_last = 1'b0;
  assign b_last = 1'b0;
  assign c_last = 1'b0;
`endif

  task automatic chk(input string nm, input int act, input int exp);
    n_tot++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, want %0d", nm, act, exp);
  endtask

  // Beat encoding: idx + 256*none + 512*last.
  function automatic int enc(input logic l, input logic n, input int i);
    return i + (n ? 256 : 0) + (l ? 512 : 0);
  endfunction

  function automatic int lm(input int e);
    return LAST ? e : (e & 511);
  endfunction

  // Monitor: compare every presented beat with the queue head.
  always @(negedge clk) begin
    if (rst_n) begin
      if (a_ov) begin
        if (qa.size() == 0) chk("a_spurious", enc(a_last, a_none, a_idx), -1);
        else begin
          chk("a_beat", enc(a_last, a_none, a_idx), lm(qa[0]));
          if (a_ordy) void'(qa.pop_front());
        end
      end
      if (b_ov) begin
        if (qb.size() == 0) chk("b_spurious", enc(b_last, b_none, b_idx), -1);
        else begin
          chk("b_beat", enc(b_last, b_none, b_idx), lm(qb[0]));
          if (b_ordy) void'(qb.pop_front());
        end
      end
      if (c_ov) begin
        if (qc.size() == 0) chk("c_spurious", enc(c_last, c_none, c_idx), -1);
        else begin
          chk("c_beat", enc(c_last, c_none, c_idx), lm(qc[0]));
          if (c_ordy) void'(qc.pop_front());
        end
      end
    end
  end

  // Reference: MSB-first index list for a 4-bit vector.
  task automatic push_a(input logic [3:0] v);
    int rem;
    rem = $countones(v);
    if (v == 4'b0) qa.push_back(768);
    else begin
      for (int i = 3; i >= 0; i--) begin
        if (v[i]) begin
          rem--;
          qa.push_back(i + ((rem == 0) ? 512 : 0));
        end
      end
    end
  endtask

  task automatic send(input int sel, input logic [7:0] v);
    int n;
    logic rdy;
    n = 0;
    rdy = (sel == 0) ? a_ir : (sel == 1) ? b_ir : c_ir;
    while (!rdy && n < 200) begin
      @(posedge clk); #1;
      n++;
      rdy = (sel == 0) ? a_ir : (sel == 1) ? b_ir : c_ir;
    end
    if (!rdy) chk("in_ready_timeout", 0, 1);
    case (sel)
      0: begin a_iv = 1'b1; a_req = v[3:0]; end
      1: begin b_iv = 1'b1; b_req = v[3:0]; end
      default: begin c_iv = 1'b1; c_req = v; end
    endcase
    @(posedge clk); #1;
    a_iv = 1'b0;
    b_iv = 1'b0;
    c_iv = 1'b0;
    a_req = 4'($urandom);
  endtask

  task automatic chk_reset(input string nm);
    chk({nm, "_ov"}, a_ov, 0);
    chk({nm, "_idx"}, a_idx, 0);
    chk({nm, "_none"}, a_none, 0);
    chk({nm, "_ir"}, a_ir, 1);
    chk({nm, "_last"}, a_last, 0);
  endtask

  initial begin
    int n;
    a_iv = 0; b_iv = 0; c_iv = 0;
    a_req = 4'hF; b_req = 0; c_req = 0;
    a_ordy = 1; b_ordy = 1; c_ordy = 1;
    done = 0;
    #1;
    chk_reset("rst0");
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;

    // 1010 MSB-first: 3 then 1, idle gap after.
    qa.push_back(3);
    qa.push_back(1 + 512);
    send(0, 8'h0A);
    chk("t1_valid_k1", a_ov, 1);
    chk("t1_idx_k1", a_idx, 3);
    @(posedge clk); #1;
    chk("t1_idx_k2", a_idx, 1);
    @(posedge clk); #1;
    chk("t1_ir_k3", a_ir, 1);
    chk("t1_ov_k3", a_ov, 0);

    // All-zero vector: one out_none beat.
    qa.push_back(768);
    send(0, 8'h00);
    chk("t0_none", a_none, 1);
    @(posedge clk); #1;
    chk("t0_ir", a_ir, 1);

    // Backpressure on 0111, in_valid pulses during drain.
    a_ordy = 1'b0;
    qa.push_back(2);
    qa.push_back(1);
    qa.push_back(0 + 512);
    send(0, 8'h07);
    a_iv = 1'b1;
    a_req = 4'hF;
    repeat (3) begin
      chk("bp_hold_idx", a_idx, 2);
      chk("bp_hold_ov", a_ov, 1);
      @(posedge clk); #1;
    end
    a_iv = 1'b0;
    a_ordy = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("bp_ir", a_ir, 1);
    chk("bp_drained", qa.size(), 0);

    // LSB-first and 8-bit instances.
    qb.push_back(1);
    qb.push_back(3 + 512);
    send(1, 8'h0A);
    qc.push_back(7);
    qc.push_back(0 + 512);
    send(2, 8'h81);
    qc.push_back(768);
    send(2, 8'h00);
    qc.push_back(6 + 512);
    send(2, 8'h40);
    repeat (4) @(posedge clk);
    #1;
    chk("b_drained", qb.size(), 0);
    chk("c_drained", qc.size(), 0);

    // Sweep all 16 vectors with random out_ready.
    fork
      begin
        for (int v = 0; v < 16; v++) begin
          push_a(4'(v));
          send(0, 8'(v));
        end
        done = 1;
      end
      begin
        while (!done) begin
          @(posedge clk); #1;
          a_ordy = 1'($urandom);
        end
      end
    join
    a_ordy = 1'b1;
    n = 0;
    while (qa.size() != 0 && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    chk("sweep_drained", qa.size(), 0);
    @(posedge clk); #1;

    // Reset after the first beat of 1111.
    push_a(4'hF);
    send(0, 8'h0F);
    @(posedge clk); #1;
    rst_n = 1'b0;
    qa.delete();
    #1;
    chk_reset("rst_mid");
    #20;
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    chk("post_rst_ov", a_ov, 0);
    chk("post_rst_ir", a_ir, 1);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
